// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage next-PC controller: FSM encoding,
// redirect-source priorities and the architectural vector addresses.
package pc_seq_pkg;

    localparam logic RUN  = 1'b0;
    localparam logic WAIT = 1'b1;

    // Redirect sources; a larger value wins arbitration.
    localparam logic [2:0] SRC_NONE   = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_ERET   = 3'd3;
    localparam logic [2:0] SRC_IRQ    = 3'd4;
    localparam logic [2:0] SRC_EXC    = 3'd5;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
    localparam logic [31:0] PC_STEP_DEF      = 32'd4;

endpackage

// File: rtl/pc_sequencer_arb.sv
// Combinational priority encoder over the redirect sources; reports the
// winning source, its target and whether it enters the handler.
module pc_redirect_arb
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        exc_req,
    input  logic        irq_take,
    input  logic        eret,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] epc,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    output logic        valid,
    output logic        is_exc,
    output logic [2:0]  src,
    output logic [31:0] target
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        valid  = 1'b1;
        is_exc = 1'b0;
        src    = SRC_NONE;
        target = '0;
        if (exc_req) begin
            is_exc = 1'b1;
            src    = SRC_EXC;
            target = EXC_VECTOR;
        end else if (irq_take) begin
            is_exc = 1'b1;
            src    = SRC_IRQ;
            target = EXC_VECTOR;
        end else if (eret) begin
            src    = SRC_ERET;
            target = epc;
        end else if (jump) begin
            src    = SRC_JUMP;
            target = jump_target;
        end else if (branch_taken) begin
            src    = SRC_BRANCH;
            target = branch_target;
        end else begin
            valid  = 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates redirects, parks one redirect while
// instruction memory is busy, drives flush strobes and owns EPC/in_handler.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter logic [31:0] PC_STEP      = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cur_pc,
    input  logic        imem_ready,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        irq,
    input  logic        irq_en,
    input  logic        eret,
    output logic [31:0] next_pc,
    output logic        pc_write,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] epc,
    output logic        in_handler
);

    logic        state, state_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic        pend_exc, pend_exc_nxt;
    logic [31:0] pend_target, pend_target_nxt;

    logic        irq_take;
    logic        arb_valid, arb_exc;
    logic [2:0]  arb_src;
    logic [31:0] arb_target;

    logic        take_new, eff_valid, eff_exc;
    logic [31:0] eff_target;

    logic [31:0] core_next_pc;
    logic        core_pc_write, core_flush_if, core_flush_id;

    assign irq_take = irq & irq_en & ~in_handler;

    pc_redirect_arb #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_arb (
        .exc_req      (exc_req),
        .irq_take     (irq_take),
        .eret         (eret),
        .jump         (jump),
        .branch_taken (branch_taken),
        .epc          (epc),
        .jump_target  (jump_target),
        .branch_target(branch_target),
        .valid        (arb_valid),
        .is_exc       (arb_exc),
        .src          (arb_src),
        .target       (arb_target)
    );

    // A held exception/irq can only be displaced by another exception/irq.
    assign take_new   = arb_valid & (~pend_valid | arb_exc | ~pend_exc);
    assign eff_valid  = take_new | pend_valid;
    assign eff_exc    = take_new ? arb_exc    : pend_exc;
    assign eff_target = take_new ? arb_target : pend_target;

    always_comb begin
        core_next_pc    = cur_pc;
        core_pc_write   = 1'b0;
        core_flush_if   = 1'b0;
        core_flush_id   = 1'b0;
        state_nxt       = state;
        pend_valid_nxt  = pend_valid;
        pend_exc_nxt    = pend_exc;
        pend_target_nxt = pend_target;

        if (eff_valid) begin
            if (imem_ready) begin
                core_next_pc   = eff_target;
                core_pc_write  = 1'b1;
                core_flush_if  = 1'b1;
                core_flush_id  = take_new & arb_exc;
                pend_valid_nxt = 1'b0;
                state_nxt      = RUN;
            end else begin
                pend_valid_nxt  = 1'b1;
                pend_exc_nxt    = eff_exc;
                pend_target_nxt = eff_target;
                core_flush_if   = take_new;
                core_flush_id   = take_new & arb_exc;
                state_nxt       = WAIT;
            end
        end else if (state == RUN || imem_ready) begin
            // An empty WAIT that sees imem_ready acts exactly like RUN.
            if (stall_req) begin
                state_nxt = RUN;
            end else if (!imem_ready) begin
                state_nxt = WAIT;
            end else begin
                core_next_pc  = cur_pc + PC_STEP;
                core_pc_write = 1'b1;
                state_nxt     = RUN;
            end
        end
    end

    // Outputs are forced to their reset values while reset is held low.
    assign next_pc  = reset ? core_next_pc : RESET_VECTOR;
    assign pc_write = reset & core_pc_write;
    assign flush_if = ~reset | core_flush_if;
    assign flush_id = ~reset | core_flush_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pend_valid  <= 1'b0;
            pend_exc    <= 1'b0;
            pend_target <= '0;
            epc         <= '0;
            in_handler  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state       <= state_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_exc    <= pend_exc_nxt;
            pend_target <= pend_target_nxt;
            if (take_new) begin
                case (arb_src)
                    SRC_EXC: begin
                        epc        <= exc_pc;
                        in_handler <= 1'b1;
                    end
                    SRC_IRQ: begin
                        epc        <= cur_pc;
                        in_handler <= 1'b1;
                    end
                    SRC_ERET: in_handler <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; a local PC register closes
// the loop so each row sees the PC produced by the previous cycle.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cur_pc;
    logic        imem_ready, stall_req, branch_taken, jump, exc_req, irq, irq_en, eret;
    logic [31:0] branch_target, jump_target, exc_pc;
    logic [31:0] next_pc, epc;
    logic        pc_write, flush_if, flush_id, in_handler;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic [31:0] pc_q;
    always @(posedge clk or negedge reset) begin
        if (!reset)        pc_q <= RESET_VECTOR_DEF;
        else if (pc_write) pc_q <= next_pc;
    end
    assign cur_pc = pc_q;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cur_pc       (cur_pc),
        .imem_ready   (imem_ready),
        .stall_req    (stall_req),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .irq          (irq),
        .irq_en       (irq_en),
        .eret         (eret),
        .next_pc      (next_pc),
        .pc_write     (pc_write),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .epc          (epc),
        .in_handler   (in_handler)
    );

    typedef struct {
        logic        ready, stall, br;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        exc;
        logic [31:0] xpc;
        logic        irq, ien, eret;
        logic [31:0] e_next;
        logic        e_wr, e_fif, e_fid;
        logic [31:0] e_epc;
        logic        e_inh, chk_fl;
    } vec_t;

    localparam int NV = 33;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] E0 = 32'h8000_0180;
    localparam logic [31:0] E4 = 32'h8000_0184;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        imem_ready    = v.ready;
        stall_req     = v.stall;
        branch_taken  = v.br;
        branch_target = v.btgt;
        jump          = v.jmp;
        jump_target   = v.jtgt;
        exc_req       = v.exc;
        exc_pc        = v.xpc;
        irq           = v.irq;
        irq_en        = v.ien;
        eret          = v.eret;
    endtask

    task automatic idle(input logic ready);
        imem_ready = ready; stall_req = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        exc_req = 1'b0; irq = 1'b0; irq_en = 1'b0; eret = 1'b0;
        branch_target = '0; jump_target = '0; exc_pc = '0;
    endtask

    initial begin
        // ready stall br btgt jmp jtgt exc xpc irq ien eret | next wr fif fid epc inh chk_fl
        vecs[0]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0004,H,L,L, Z,L,H};
        vecs[1]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0008,H,L,L, Z,L,H};
        vecs[2]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_000C,H,L,L, Z,L,H};
        vecs[3]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0010,H,L,L, Z,L,H};
        vecs[4]  = '{H,H, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0010,L,L,L, Z,L,H};
        vecs[5]  = '{H,H, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0010,L,L,L, Z,L,H};
        vecs[6]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0014,H,L,L, Z,L,H};
        vecs[7]  = '{H,L, L,Z, L,Z, L,Z, H,L,L, 32'h0040_0018,H,L,L, Z,L,H};
        vecs[8]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_001C,H,L,L, Z,L,H};
        vecs[9]  = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0020,H,L,L, Z,L,H};
        vecs[10] = '{H,L, L,Z, L,Z, L,Z, H,H,L, E0,H,H,H, Z,L,H};
        vecs[11] = '{H,L, L,Z, L,Z, L,Z, H,H,L, E4,H,L,L, 32'h0040_0020,H,H};
        vecs[12] = '{H,L, L,Z, L,Z, L,Z, L,L,H, 32'h0040_0020,H,H,L, 32'h0040_0020,H,H};
        vecs[13] = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0024,H,L,L, 32'h0040_0020,L,H};
        vecs[14] = '{H,L, H,32'h0040_0200, H,32'h0040_0100, L,Z, L,L,L, 32'h0040_0100,H,H,L, 32'h0040_0020,L,H};
        vecs[15] = '{L,L, H,32'h0040_0040, L,Z, L,Z, L,L,L, 32'h0040_0100,L,H,L, 32'h0040_0020,L,H};
        vecs[16] = '{L,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0100,L,L,L, 32'h0040_0020,L,H};
        vecs[17] = '{L,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0100,L,L,L, 32'h0040_0020,L,H};
        vecs[18] = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0040,H,L,L, 32'h0040_0020,L,L};
        vecs[19] = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0040_0044,H,L,L, 32'h0040_0020,L,H};
        vecs[20] = '{H,H, L,Z, L,Z, H,32'h0040_0030, L,L,L, E0,H,H,H, 32'h0040_0020,L,H};
        vecs[21] = '{H,L, L,Z, L,Z, L,Z, L,L,L, E4,H,L,L, 32'h0040_0030,H,H};
        vecs[22] = '{L,L, H,32'h0040_0300, L,Z, L,Z, L,L,L, E4,L,H,L, 32'h0040_0030,H,H};
        vecs[23] = '{L,L, L,Z, L,Z, H,32'h0040_0050, L,L,L, E4,L,L,L, 32'h0040_0030,H,L};
        vecs[24] = '{L,L, L,Z, H,32'h0040_0400, L,Z, L,L,L, E4,L,L,L, 32'h0040_0050,H,L};
        vecs[25] = '{H,L, L,Z, L,Z, L,Z, L,L,L, E0,H,L,L, 32'h0040_0050,H,L};
        vecs[26] = '{H,L, L,Z, L,Z, L,Z, L,L,H, 32'h0040_0050,H,H,L, 32'h0040_0050,H,H};
        vecs[27] = '{H,L, L,Z, H,32'hFFFF_FFFC, L,Z, L,L,L, 32'hFFFF_FFFC,H,H,L, 32'h0040_0050,L,H};
        vecs[28] = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0000_0000,H,L,L, 32'h0040_0050,L,H};
        vecs[29] = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0000_0004,H,L,L, 32'h0040_0050,L,H};
        vecs[30] = '{L,L, L,Z, L,Z, L,Z, L,L,L, 32'h0000_0004,L,L,L, 32'h0040_0050,L,H};
        vecs[31] = '{H,H, L,Z, L,Z, L,Z, L,L,L, 32'h0000_0004,L,L,L, 32'h0040_0050,L,H};
        vecs[32] = '{H,L, L,Z, L,Z, L,Z, L,L,L, 32'h0000_0008,H,L,L, 32'h0040_0050,L,H};

        idle(1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("reset next_pc",    next_pc,           RESET_VECTOR_DEF);
        check("reset pc_write",   32'(pc_write),     32'd0);
        check("reset flush_if",   32'(flush_if),     32'd1);
        check("reset flush_id",   32'(flush_id),     32'd1);
        check("reset epc",        epc,               32'd0);
        check("reset in_handler", 32'(in_handler),   32'd0);

        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("row%0d next_pc", i),    next_pc,          vecs[i].e_next);
            check($sformatf("row%0d pc_write", i),   32'(pc_write),    32'(vecs[i].e_wr));
            check($sformatf("row%0d epc", i),        epc,              vecs[i].e_epc);
            check($sformatf("row%0d in_handler", i), 32'(in_handler),  32'(vecs[i].e_inh));
            if (vecs[i].chk_fl) begin
                check($sformatf("row%0d flush_if", i), 32'(flush_if), 32'(vecs[i].e_fif));
                check($sformatf("row%0d flush_id", i), 32'(flush_id), 32'(vecs[i].e_fid));
            end
        end

        // Asynchronous reset in the middle of WAIT must discard the held branch.
        @(posedge clk);
        #1;
        idle(1'b0);
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0700;
        @(posedge clk);
        #1 branch_taken = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async next_pc",    next_pc,         RESET_VECTOR_DEF);
        check("async pc_write",   32'(pc_write),   32'd0);
        check("async flush_if",   32'(flush_if),   32'd1);
        check("async flush_id",   32'(flush_id),   32'd1);
        check("async epc",        epc,             32'd0);
        check("async in_handler", 32'(in_handler), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1'b1);
        @(negedge clk);
        check("post-reset next_pc",  next_pc,        32'h0040_0004);
        check("post-reset pc_write", 32'(pc_write),  32'd1);
        check("post-reset flush_if", 32'(flush_if),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
